// File: rtl/pingpong_line_buffer.sv
// pingpong_line_buffer: two-bank line buffer; the producer fills one bank line by line
// while the consumer drains the other bank one NUM_LINES-tall column per beat.
module pingpong_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 1,
    parameter int NUM_LINES  = 3,
    parameter int LINE_LEN   = 64,
    localparam int COL_W     = $clog2(LINE_LEN),
    localparam int PW        = CHANNELS * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PW-1:0]           in_data,
    input  logic                    in_eol,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_LINES*PW-1:0] out_data,
    output logic [COL_W-1:0]        out_col,
    output logic                    out_last,
    output logic [1:0]              bank_full,
    output logic                    err_len
);
    localparam int LW = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
    localparam int NW = COL_W + 1;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} state_t;
    state_t           st_q [2];
    state_t           st_d [2];
    logic [NW-1:0]    ncols_q [2];
    logic [NW-1:0]    ncols_d [2];
    logic             wb_q, wb_d, rb_q, rb_d, err_q, err_d;
    logic [LW-1:0]    wline_q, wline_d;
    logic [COL_W-1:0] wcol_q, wcol_d, rcol_q, rcol_d;
    logic [PW-1:0]    mem_q [2][NUM_LINES][LINE_LEN];
    logic             wr, rd, line_end, bank_done;
    logic [NW-1:0]    wlen;

    assign in_ready  = st_q[wb_q] == EMPTY || st_q[wb_q] == FILLING;
    assign out_valid = st_q[rb_q] == FULL || st_q[rb_q] == DRAINING;
    assign out_last  = out_valid && {1'b0, rcol_q} == ncols_q[rb_q] - 1'b1;
    assign out_col   = rcol_q;
    assign err_len   = err_q;
    assign wr        = in_valid && in_ready;
    assign rd        = out_valid && out_ready;
    // a beat landing in the last column closes the line even without in_eol
    assign line_end  = wr && (in_eol || wcol_q == COL_W'(LINE_LEN - 1));
    assign bank_done = line_end && wline_q == LW'(NUM_LINES - 1);
    assign wlen      = {1'b0, wcol_q} + 1'b1;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_full[b] = st_q[b] == FULL || st_q[b] == DRAINING;
    end
    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        assign out_data[l*PW +: PW] = mem_q[rb_q][l][rcol_q];
    end

    // writer only touches an EMPTY/FILLING bank and reader a FULL/DRAINING one, so both apply freely
    always_comb begin
        st_d    = st_q;
        ncols_d = ncols_q;
        wb_d    = wb_q;
        rb_d    = rb_q;
        err_d   = err_q;
        wline_d = wline_q;
        wcol_d  = wcol_q;
        rcol_d  = rcol_q;
        if (wr) begin
            st_d[wb_q] = bank_done ? FULL : FILLING;
            wcol_d     = line_end ? '0 : wcol_q + 1'b1;
        end
        if (line_end) begin
            wline_d = bank_done ? '0 : wline_q + 1'b1;
            wb_d    = wb_q ^ bank_done;
            if (wline_q == '0) ncols_d[wb_q] = wlen;
            else if (wlen != ncols_q[wb_q]) err_d = 1'b1;
        end
        if (rd) begin
            st_d[rb_q] = out_last ? EMPTY : DRAINING;
            rcol_d     = out_last ? '0 : rcol_q + 1'b1;
            rb_d       = rb_q ^ out_last;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= '{EMPTY, EMPTY};
            ncols_q <= '{default: '0};
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            err_q   <= 1'b0;
            wline_q <= '0;
            wcol_q  <= '0;
            rcol_q  <= '0;
        end else begin
            st_q    <= st_d;
            ncols_q <= ncols_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            err_q   <= err_d;
            wline_q <= wline_d;
            wcol_q  <= wcol_d;
            rcol_q  <= rcol_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wb_q][wline_q][wcol_q] <= in_data;
    end
endmodule

// File: tb/tb_pingpong_line_buffer.sv
// tb_pingpong_line_buffer: directed and random traffic against a bank-queue model.
module tb_pingpong_line_buffer;
    localparam int DW = 8, CH = 2, NL = 3, LL = 8, PW = DW * CH, CW = 3;
    logic clk = 0, reset = 1, in_valid = 0, in_eol = 0, out_ready = 0;
    logic [PW-1:0] in_data = '0;
    logic in_ready, out_valid, out_last, err_len;
    logic [NL*PW-1:0] out_data;
    logic [CW-1:0] out_col;
    logic [1:0] bank_full;

    pingpong_line_buffer #(.DATA_WIDTH(DW), .CHANNELS(CH), .NUM_LINES(NL), .LINE_LEN(LL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_eol(in_eol), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last), .bank_full(bank_full), .err_len(err_len)
    );

    always #5 clk = ~clk;

    // completed banks awaiting the consumer, oldest first
    typedef struct {int b; int n;} bank_t;
    bank_t held[$];
    logic [PW-1:0] mm [2][NL][LL];
    bit kn [2][NL][LL];
    int wbank, wline, wcol, cur_n, rcol;
    bit err_m;
    int vec = 0, bad = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vec++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        held.delete();
        wbank = 0; wline = 0; wcol = 0; cur_n = 0; rcol = 0; err_m = 0;
    endtask

    task automatic check_all();
        bit v, el;
        logic [1:0] bf;
        v = held.size() > 0;
        el = 0;
        bf = 0;
        foreach (held[i]) bf[held[i].b] = 1;
        if (v) el = rcol == held[0].n - 1;
        chk("in_ready", in_ready, held.size() < 2);
        chk("out_valid", out_valid, v);
        chk("out_col", out_col, rcol);
        chk("out_last", out_last, el);
        chk("bank_full", bank_full, bf);
        chk("err_len", err_len, err_m);
        if (v)
            for (int l = 0; l < NL; l++)
                if (kn[held[0].b][l][rcol]) chk("out_data", out_data[l*PW +: PW], mm[held[0].b][l][rcol]);
    endtask

    task automatic model_edge(bit v, logic [PW-1:0] d, bit e, bit r);
        bit acc_w, acc_r;
        acc_w = v && held.size() < 2;
        acc_r = r && held.size() > 0;
        if (acc_r) begin
            if (rcol == held[0].n - 1) begin
                void'(held.pop_front());
                rcol = 0;
            end else rcol++;
        end
        if (acc_w) begin
            mm[wbank][wline][wcol] = d;
            kn[wbank][wline][wcol] = 1;
            if (e || wcol == LL - 1) begin
                if (wline == 0) cur_n = wcol + 1;
                else if (wcol + 1 != cur_n) err_m = 1;
                wcol = 0;
                if (wline == NL - 1) begin
                    held.push_back('{wbank, cur_n});
                    wbank ^= 1;
                    wline = 0;
                end else wline++;
            end else wcol++;
        end
    endtask

    task automatic cyc(bit v, logic [PW-1:0] d, bit e, bit r);
        @(negedge clk);
        in_valid = v; in_data = d; in_eol = e; out_ready = r;
        #1 check_all();
        @(posedge clk);
        model_edge(v, d, e, r);
    endtask

    task automatic do_reset();
        #1 in_valid = 0; out_ready = 0; in_eol = 0;
        #1 reset = 1;
        model_reset();
        #1 check_all();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_bank_full", bank_full, 2'b00);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk) reset = 0;
    endtask

    function automatic logic [PW-1:0] pix(int l, int c);
        logic [7:0] b;
        b = 8'(l * 16 + c);
        return {b, b};
    endfunction

    task automatic write_line(int n, bit eol, bit r, int l, bit rnd);
        for (int c = 0; c < n; c++) cyc(1, rnd ? PW'($urandom) : pix(l, c), eol && c == n - 1, r);
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 1);
    endtask

    initial begin
        foreach (kn[b, l, c]) kn[b][l][c] = 0;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0);
        chk("t1_err", err_len, 1'b0);
        // 3 lines of 4 pixels, consumer stalled
        for (int l = 0; l < 3; l++) write_line(4, 1, 0, l, 0);
        #1 chk("t2_bank_full", bank_full, 2'b01);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_col", out_col, 0);
        chk("t2_data", out_data, 48'h2020_1010_0000);
        drain(3);
        #1 chk("t2_col3", out_col, 3);
        chk("t2_last3", out_last, 1'b1);
        drain(1);
        #1 chk("t2_empty", bank_full, 2'b00);
        // both banks filled, then drained
        do_reset();
        for (int l = 0; l < 6; l++) write_line(5, 1, 0, l, 1);
        #1 chk("t3_full", bank_full, 2'b11);
        chk("t3_ready", in_ready, 1'b0);
        cyc(1, 16'hdead, 1, 0);
        drain(5);
        #1 chk("t3_ready_back", in_ready, 1'b1);
        chk("t3_bank1", bank_full, 2'b10);
        drain(5);
        // implicit end of line at max length
        for (int l = 0; l < 3; l++) write_line(8, 0, 0, l, 1);
        drain(7);
        #1 chk("t4_col7", out_col, 7);
        chk("t4_last7", out_last, 1'b1);
        drain(1);
        // mismatched line lengths
        write_line(4, 1, 0, 0, 1);
        write_line(3, 1, 0, 1, 1);
        #1 chk("t5_err", err_len, 1'b1);
        write_line(4, 1, 0, 2, 1);
        #1 chk("t5_err_sticky", err_len, 1'b1);
        drain(3);
        #1 chk("t5_last", out_last, 1'b1);
        drain(1);
        // reset while bank 1 fills and bank 0 drains
        do_reset();
        for (int l = 0; l < 3; l++) write_line(4, 1, 0, l, 1);
        cyc(1, PW'($urandom), 0, 1);
        cyc(1, PW'($urandom), 0, 1);
        cyc(1, PW'($urandom), 0, 0);
        cyc(1, PW'($urandom), 1, 0);
        write_line(2, 0, 0, 1, 1);
        #1 chk("t6_col2", out_col, 2);
        do_reset();
        for (int l = 0; l < 3; l++) write_line(2, 1, 0, l, 1);
        #1 chk("t6_bank0", bank_full, 2'b01);
        drain(2);
        // random traffic
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 3) != 0, PW'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
